regfile_clr: RTL and testbench
==============================

// Module: regfile_clr
//
// PURPOSE
// - Parametrised successor to the core's integer register file: XLEN-wide, DEPTH entries, NUM_RD read ports, one write port.
// - Adds a hardwired zero register, a sequenced hardware clear (after reset or on request) with a busy flag, and optional write-to-read bypass.
// - Sits between decode (read addresses) and writeback (write port). Decode stalls while busy is high.
//
// PARAMETERS
// - XLEN     32               data width of each entry
// - DEPTH    32               number of entries, 2..256, need not be a power of 2
// - NUM_RD   2                number of combinational read ports, 1..4
// - ADDR_W   $clog2(DEPTH)    address width (derived; do not override)
// - ZERO_REG 1                1: entry 0 always reads 0 and ignores writes; 0: entry 0 is ordinary
//
// PORTS
// - clk      in   1              clock; all state changes on its rising edge
// - rst_n    in   1              synchronous reset, active-low
// - we       in   1              write enable
// - waddr    in   ADDR_W         write address
// - wdata    in   XLEN           write data
// - raddr    in   NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
// - rdata    out  NUM_RD*XLEN    read data, port i at [i*XLEN +: XLEN]
// - clr_req  in   1              one-cycle pulse: request clear of all entries
// - busy     out  1              high while a clear sequence runs
//
// BEHAVIOUR
// - One clock; reset is synchronous and active-low: rst_n is sampled on the rising edge of clk, nothing is asynchronous.
// - FSM: two states, CLEAR and READY. A clear pointer clr_ptr (ADDR_W bits) steps through the entries.
// - Reset: rst_n low at an edge -> state=CLEAR, clr_ptr=0, busy=1. Reset value of busy is 1, and rdata is all 0 during reset.
// - CLEAR: one entry is written to 0 per cycle, at index clr_ptr; clr_ptr then increments.
//   - The edge that clears entry DEPTH-1 moves state to READY, so busy=0 from that edge on.
//   - Result: busy stays high for exactly DEPTH edges after rst_n returns high.
// - Inside CLEAR:
//   - we is ignored.
//   - clr_req is ignored; the sequence is not restarted.
//   - every rdata port reads 0.
// - READY, write: we=1 writes wdata to entry waddr at the edge. Data is visible on rdata from the following cycle.
// - READY, reads: rdata[i] = entry[raddr[i]], combinational, zero latency. Any number of ports may read the same address.
// - ZERO_REG=1:
//   - a write to address 0 is dropped;
//   - a read of address 0 returns 0;
//   - the bypass never forwards for address 0.
// - Out of range (waddr or raddr >= DEPTH): the write is dropped and the read returns 0. No error flag.
// - clr_req=1 in READY: next state=CLEAR, clr_ptr=0, busy=1 from the next edge.
//   - If we is also 1 in that cycle, the write is still performed; the clear then zeroes the entry.
// - rst_n low in mid-clear: clr_ptr restarts at 0; the full DEPTH-cycle sequence runs again.
// - Storage width is exactly XLEN per entry; there is no truncation or extension.
//
// CONFIGURATION
// - Macro REGFILE_BYPASS_EN.
// - Defined: in READY with we=1, a valid waddr and waddr==raddr[i], rdata[i]=wdata in the same cycle (write-through).
//   - Address 0 is never forwarded when ZERO_REG=1.
//   - Forwarding never happens in CLEAR.
// - Undefined: rdata[i] returns the pre-write contents during the write cycle.
//   - The new value appears from the cycle after the edge.
//
// TESTING
// - Reset, DEPTH=32: hold rst_n=0 for 2 cycles, then release -> busy=1 for exactly 32 edges, then 0. Every address then reads 0x00000000.
// - When READY: write 5<-0xDEADBEEF, then read raddr={5,5} on the next cycle -> both ports return 0xDEADBEEF.
// - Zero register and range, ZERO_REG=1, DEPTH=24:
//   - write 0<-0x12345678 -> address 0 reads 0;
//   - write 30<-0x1 -> dropped, address 30 reads 0.
// - Bypass: write 7<-0xA5A5A5A5 while raddr[0]=7 in the same cycle.
//   - Defined: rdata[0]=0xA5A5A5A5 in that cycle.
//   - Undefined: rdata[0]=old value, and 0xA5A5A5A5 on the next cycle.
// - Clear request: fill entries 1..31 with nonzero values, then pulse clr_req together with we (3<-0xFF).
//   - busy goes high for 32 edges;
//   - writes and a second clr_req during busy have no effect;
//   - afterwards every entry reads 0.
// - Reset in mid-clear: pull rst_n low at clr_ptr=10 -> the clear restarts from 0 and busy stays high for 32 edges after release.

Source files
------------

// File: rtl/regfile_clr.sv
// regfile_clr: integer register file with hardwired zero entry, sequenced hardware clear
// and optional write-to-read bypass.
//
// Parameters
//   XLEN     data width of each entry
//   DEPTH    number of entries (2..256, need not be a power of two)
//   NUM_RD   number of combinational read ports (1..4)
//   ADDR_W   address width, derived from DEPTH; do not override
//   ZERO_REG 1: entry 0 reads 0 and ignores writes; 0: entry 0 is ordinary
//
// Ports
//   clk      clock, all state changes on the rising edge
//   rst_n    synchronous active-low reset
//   we       write enable
//   waddr    write address
//   wdata    write data
//   raddr    read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata    read data, port i at [i*XLEN +: XLEN]
//   clr_req  one-cycle pulse requesting a clear of every entry
//   busy     high while a clear sequence runs; decode stalls on it
//
// Build option
//   REGFILE_BYPASS_EN  when defined, a READY-state write to a valid address is forwarded
//                      combinationally to any read port addressing it in the same cycle.

module regfile_clr #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [XLEN-1:0]          wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*XLEN-1:0]   rdata,
    input  logic                     clr_req,
    output logic                     busy
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (DEPTH < 2 || DEPTH > 256) begin : g_bad_depth
        $error("regfile_clr: DEPTH must be in 2..256");
    end
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
        $error("regfile_clr: NUM_RD must be in 1..4");
    end
    if (ADDR_W != $clog2(DEPTH)) begin : g_bad_addr_w
        $error("regfile_clr: ADDR_W is derived from DEPTH and must not be overridden");
    end

    // One extra bit so DEPTH=256 with ADDR_W=8 still compares correctly.
    localparam logic [ADDR_W:0]   DepthExt = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        StClear,
        StReady
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [XLEN-1:0]     mem_q [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [XLEN-1:0]     mem_wdata;
    logic                wr_user;
    logic                clr_last;
    logic                ready;

    // Address is backed by real storage (not out of range, not the hardwired zero).
    function automatic logic addr_live(input logic [ADDR_W-1:0] a);
        logic in_range;
        in_range = ({1'b0, a} < DepthExt);
        return in_range && !(ZERO_REG && (a == '0));
    endfunction

    assign ready    = (state_q == StReady);
    assign busy     = (state_q == StClear);
    assign clr_last = (clr_ptr_q == LastIdx);
    assign wr_user  = rst_n && ready && we && addr_live(waddr);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        unique case (state_q)
            StClear: begin
                // clr_req is ignored here; the running sequence just continues.
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_last) begin
                    state_d   = StReady;
                    clr_ptr_d = '0;
                end
            end
            StReady: begin
                if (clr_req) begin
                    state_d   = StClear;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                state_d   = StClear;
                clr_ptr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StClear;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Single storage write port, shared by the clear sequencer and writeback.
    // A clr_req cycle still takes the user write; the clear then zeroes it.
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = waddr;
        mem_wdata = wdata;
        if (rst_n) begin
            if (busy) begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = '0;
            end else if (wr_user) begin
                mem_we    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [XLEN-1:0]   rd;
        logic              fwd;

        assign ra = raddr[i*ADDR_W +: ADDR_W];

`ifdef REGFILE_BYPASS_EN
        // wr_user already excludes CLEAR, invalid addresses and the zero entry.
        assign fwd = wr_user && (waddr == ra);
`else
        assign fwd = 1'b0;
`endif

        always_comb begin
            rd = '0;
            // Reads are forced to zero during reset and while the clear runs.
            if (rst_n && ready && addr_live(ra)) begin
                rd = fwd ? wdata : mem_q[ra];
            end
        end

        assign rdata[i*XLEN +: XLEN] = rd;
    end

endmodule

// File: tb/tb_regfile_clr.sv
module tb_regfile_clr;

    localparam int AW = 5;
    localparam int NR = 2;

    logic          clk = 1'b0;
    logic          rst_n, we, clr_req;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic [NR*AW-1:0] raddr;
    logic [NR*32-1:0] rdata32, rdata24;
    logic          busy32, busy24;

    always #5 clk = ~clk;

    regfile_clr #(.XLEN(32), .DEPTH(32), .NUM_RD(NR), .ZERO_REG(1'b1)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata32), .clr_req(clr_req), .busy(busy32)
    );

    regfile_clr #(.XLEN(32), .DEPTH(24), .NUM_RD(NR), .ZERO_REG(1'b1)) u_dut24 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata24), .clr_req(clr_req), .busy(busy24)
    );

    // Reference model: contents per instance plus the number of busy edges left.
    logic [31:0] mdl [2][32];
    int          remaining [2];
    int          depth_of [2] = '{32, 24};

    int n_checks = 0;
    int n_pass   = 0;
    logic seen_busy32, seen_busy24;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0, ra1;
        logic [31:0] e32_0, e32_1, e24_0, e24_1;
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] exp_rd(input int k, input logic [AW-1:0] a);
        if (!rst_n || remaining[k] > 0) return 32'h0;
        if (a == 0 || int'(a) >= depth_of[k]) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && waddr == a) return wdata;
`endif
        return mdl[k][a];
    endfunction

    task automatic wipe(input int k);
        for (int j = 0; j < 32; j++) mdl[k][j] = 32'h0;
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                remaining[k] = depth_of[k];
                wipe(k);
            end else if (remaining[k] > 0) begin
                remaining[k]--;
            end else begin
                if (we && waddr != 0 && int'(waddr) < depth_of[k]) mdl[k][waddr] = wdata;
                if (clr_req) begin
                    remaining[k] = depth_of[k];
                    wipe(k);
                end
            end
        end
    endtask

    task automatic tick_check(input bit chk);
        @(negedge clk);
        seen_busy32 = busy32;
        seen_busy24 = busy24;
        if (chk) begin
            check("busy32", {31'b0, busy32}, {31'b0, remaining[0] > 0});
            check("busy24", {31'b0, busy24}, {31'b0, remaining[1] > 0});
            for (int p = 0; p < NR; p++) begin
                check($sformatf("rd32[%0d] a=%0d", p, raddr[p*AW +: AW]),
                      rdata32[p*32 +: 32], exp_rd(0, raddr[p*AW +: AW]));
                check($sformatf("rd24[%0d] a=%0d", p, raddr[p*AW +: AW]),
                      rdata24[p*32 +: 32], exp_rd(1, raddr[p*AW +: AW]));
            end
        end
    endtask

    task automatic tick_edge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cycle(input bit chk);
        tick_check(chk);
        tick_edge();
    endtask

    task automatic idle();
        we = 1'b0;
        clr_req = 1'b0;
    endtask

    // Count cycles with busy high; optionally hammer writes and a second clr_req meanwhile.
    task automatic count_busy(input bit noisy, output int c32, output int c24);
        c32 = 0;
        c24 = 0;
        for (int i = 0; i < 100; i++) begin
            if (noisy) begin
                we      = (i < 20);
                waddr   = AW'($urandom_range(0, 31));
                wdata   = $urandom;
                clr_req = (i == 5);
                raddr   = NR*AW'($urandom);
            end
            cycle(1'b1);
            if (seen_busy32) c32++;
            if (seen_busy24) c24++;
            if (!seen_busy32 && !seen_busy24) break;
        end
        idle();
    endtask

    task automatic sweep_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            raddr = {AW'(31 - a), AW'(a)};
            tick_check(1'b1);
            check({tag, "_32"}, rdata32[31:0], 32'h0);
            check({tag, "_24"}, rdata24[31:0], 32'h0);
            tick_edge();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c32, c24;

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd1,  32'h0, 32'h0, 32'h0, 32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,
                    32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd0,  32'h12345678, 5'd5,  5'd1,
                    32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,
                    32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 5'd30, 32'h1,        5'd5,  5'd0,
                    32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
        vecs[5] = '{1'b0, 5'd0,  32'h0,        5'd30, 5'd30, 32'h1, 32'h1, 32'h0, 32'h0};
        vecs[6] = '{1'b1, 5'd23, 32'hCAFEF00D, 5'd30, 5'd5,
                    32'h1, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
        vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd23, 5'd24,
                    32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 32'h0};
        vecs[8] = '{1'b1, 5'd24, 32'h11111111, 5'd23, 5'd31,
                    32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 32'h0};
        vecs[9] = '{1'b0, 5'd0,  32'h0,        5'd24, 5'd0,  32'h11111111, 32'h0, 32'h0, 32'h0};

        rst_n = 1'b0; we = 1'b0; clr_req = 1'b0; waddr = '0; wdata = '0; raddr = '0;
        remaining[0] = 0; remaining[1] = 0;
        wipe(0); wipe(1);

        // Reset held two cycles; outputs undefined before the first edge.
        cycle(1'b0);
        cycle(1'b1);
        rst_n = 1'b1;
        count_busy(1'b0, c32, c24);
        check("reset_busy_edges_32", c32, 32);
        check("reset_busy_edges_24", c24, 24);
        sweep_zero("post_reset_zero");

        // Table-driven READY-state vectors, independent of bypass.
        for (int v = 0; v < 10; v++) begin
            we = vecs[v].we; waddr = vecs[v].wa; wdata = vecs[v].wd;
            raddr = {vecs[v].ra1, vecs[v].ra0};
            tick_check(1'b1);
            check($sformatf("vec%0d_32_p0", v), rdata32[31:0],  vecs[v].e32_0);
            check($sformatf("vec%0d_32_p1", v), rdata32[63:32], vecs[v].e32_1);
            check($sformatf("vec%0d_24_p0", v), rdata24[31:0],  vecs[v].e24_0);
            check($sformatf("vec%0d_24_p1", v), rdata24[63:32], vecs[v].e24_1);
            tick_edge();
        end
        idle();

        // Same-cycle write/read of entry 7.
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr = {5'd5, 5'd7};
        tick_check(1'b1);
`ifdef REGFILE_BYPASS_EN
        check("bypass_same_cycle", rdata32[31:0], 32'hA5A5A5A5);
`else
        check("no_bypass_same_cycle", rdata32[31:0], 32'h0);
`endif
        check("bypass_other_port", rdata32[63:32], 32'hDEADBEEF);
        tick_edge();
        idle();
        raddr = {5'd0, 5'd7};
        tick_check(1'b1);
        check("write7_next_cycle", rdata32[31:0], 32'hA5A5A5A5);
        tick_edge();

        // Fill 1..31, then clear request together with a write.
        for (int a = 1; a < 32; a++) begin
            we = 1'b1; waddr = AW'(a); wdata = 32'h0100_0000 + a; raddr = {AW'(a), AW'(a - 1)};
            cycle(1'b1);
        end
        we = 1'b1; waddr = 5'd3; wdata = 32'hFF; clr_req = 1'b1; raddr = {5'd3, 5'd9};
        tick_check(1'b1);
        check("pre_clear_read9", rdata32[31:0], 32'h0100_0009);
        tick_edge();
        idle();
        count_busy(1'b1, c32, c24);
        check("clr_busy_edges_32", c32, 32);
        check("clr_busy_edges_24", c24, 24);
        sweep_zero("post_clear_zero");

        // Reset while the clear pointer is at 10.
        clr_req = 1'b1;
        cycle(1'b1);
        idle();
        for (int i = 0; i < 10; i++) cycle(1'b1);
        rst_n = 1'b0;
        cycle(1'b1);
        rst_n = 1'b1;
        count_busy(1'b0, c32, c24);
        check("midclear_busy_edges_32", c32, 32);
        check("midclear_busy_edges_24", c24, 24);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst_n   = ($urandom_range(0, 149) != 0);
            we      = ($urandom_range(0, 2) != 0);
            waddr   = AW'($urandom_range(0, 31));
            wdata   = $urandom;
            clr_req = ($urandom_range(0, 49) == 0);
            raddr   = ($urandom_range(0, 3) == 0) ? {waddr, waddr} : NR*AW'($urandom);
            cycle(1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
